// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: circular character FIFO between a receiver and a UART
// transmitter. Each received character is stored and handed to the
// transmitter one frame at a time. A single-cycle tx_start request is issued
// whenever the transmitter is idle and data is waiting. A sticky flag records
// any characters dropped because the buffer was full.
module uart_tx_buffer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  in_valid,
  input  logic [DATA_BITS-1:0]  in_data,
  input  logic                  tx_ready,
  output logic                  tx_start,
  output logic [DATA_BITS-1:0]  tx_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    WAIT_BUSY
  } state_t;

  state_t                  state;
  logic [DATA_BITS-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   rd_ptr;
  logic                    pop;
  logic                    push;
  logic                    drop;

  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);

  // The head character leaves on the same edge that raises tx_start.
  assign pop  = (state == IDLE) && tx_ready && !empty;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // Character storage; it needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Issue FSM: request one character, then wait for the transmitter to go busy.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_ready && !empty) begin
            tx_start <= 1'b1;
            tx_data  <= mem[rd_ptr];
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!tx_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: scoreboard bench for uart_tx_buffer. Stimulus queues the
// characters it expects to see transmitted. An independent monitor pops and
// compares them on every tx_start. A small transmitter model drops tx_ready
// for a configurable number of cycles after each accepted request.
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       tx_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       clear_overflow = 1'b0;

  logic        tx_en = 1'b0;
  logic        busy = 1'b0;
  int unsigned busy_len = 3;

  logic [7:0] exp_q [$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  assign tx_ready = tx_en & ~busy;

  always #5 clk = ~clk;

  uart_tx_buffer #(
    .DATA_BITS (8),
    .DEPTH_LOG2(4)
  ) dut (
    .clk           (clk),
    .n_reset       (n_reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .tx_ready      (tx_ready),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .overflow      (overflow),
    .clear_overflow(clear_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Transmitter model: accepts on the edge after tx_start, then stays busy.
  initial begin
    forever begin
      @(negedge clk);
      if (n_reset && tx_start && tx_ready) begin
        @(posedge clk);
        #1 busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 busy = 1'b0;
      end
    end
  end

  // Monitor: every tx_start must match the next queued character.
  initial begin
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (n_reset && tx_start) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_tx_start: got tx_data=%02h, required no tx_start", tx_data);
        end else begin
          want = exp_q.pop_front();
          check("tx_data_order", 32'(tx_data), 32'(want));
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] d, input bit accept);
    in_valid = 1'b1;
    in_data  = d;
    if (accept) exp_q.push_back(d);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int unsigned limit);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (busy_len + 4) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
    check({name, "_count"}, 32'(count), 32'd0);
  endtask

  // Directed test sequence.
  initial begin
    #2 n_reset = 1'b0;
    #1;
    check("reset_count", 32'(count), 32'd0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full", 32'(full), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    tx_en   = 1'b1;
    @(posedge clk);
    #1;

    // Single byte with two-cycle latency.
    push_byte(8'h54, 1'b1);
    check("single_count_after_push", 32'(count), 32'd1);
    check("single_no_early_start", 32'(tx_start), 32'd0);
    @(posedge clk);
    #1;
    check("single_tx_start", 32'(tx_start), 32'd1);
    check("single_tx_data", 32'(tx_data), 32'h54);
    check("single_empty", 32'(empty), 32'd1);
    drain("single_drain", 50);

    // Burst fill to full, then drain through a slow transmitter.
    tx_en = 1'b0;
    for (int i = 1; i <= 16; i++) push_byte(8'(i), 1'b1);
    check("burst_full", 32'(full), 32'd1);
    check("burst_count", 32'(count), 32'd16);
    busy_len = 100;
    tx_en = 1'b1;
    drain("burst_drain", 2500);
    busy_len = 3;

    // Overflow, clear, and set-wins-over-clear.
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), 1'b1);
    push_byte(8'hAA, 1'b0);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    @(posedge clk);
    #1 clear_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    clear_overflow = 1'b1;
    push_byte(8'hBB, 1'b0);
    clear_overflow = 1'b0;
    check("ovf_set_wins", 32'(overflow), 32'd1);
    check("ovf_set_wins_count", 32'(count), 32'd16);
    clear_overflow = 1'b1;
    @(posedge clk);
    #1 clear_overflow = 1'b0;
    check("ovf_cleared_again", 32'(overflow), 32'd0);
    tx_en = 1'b1;
    drain("ovf_drain", 300);

    // Push and pop on the same edge while full.
    tx_en = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'h30 + 8'(i), 1'b1);
    tx_en = 1'b1;
    push_byte(8'h5A, 1'b1);
    check("pushpop_count", 32'(count), 32'd16);
    check("pushpop_overflow", 32'(overflow), 32'd0);
    check("pushpop_tx_start", 32'(tx_start), 32'd1);
    drain("pushpop_drain", 300);

    // Wrap-around: 40 characters in four bursts of ten.
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 10; i++) begin
        if (g == 3 && i == 9) push_byte(8'hC3, 1'b1);
        else push_byte(8'($urandom_range(0, 255)), 1'b1);
      end
      drain("wrap_drain", 300);
    end
    check("wrap_last_data", 32'(tx_data), 32'hC3);

    // Asynchronous reset with characters stored.
    tx_en = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i), 1'b1);
    check("mid_count_before", 32'(count), 32'd5);
    #3 n_reset = 1'b0;
    #1;
    check("mid_count", 32'(count), 32'd0);
    check("mid_empty", 32'(empty), 32'd1);
    check("mid_tx_data", 32'(tx_data), 32'd0);
    check("mid_tx_start", 32'(tx_start), 32'd0);
    exp_q.delete();
    #1 n_reset = 1'b1;
    tx_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("mid_idle_count", 32'(count), 32'd0);
    push_byte(8'h77, 1'b1);
    drain("mid_new_push", 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 Parameter DATA_BITS, default 8: width of one character.
REQ-002 Parameter DEPTH_LOG2, default 4: FIFO holds 2^DEPTH_LOG2 characters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 n_reset  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  one-cycle strobe from receiver: in_data holds a new character.
REQ-006 in_data  input  DATA_BITS  received character, sampled only when in_valid=1.
REQ-007 tx_ready  input  1  transmitter idle; it accepts a character when tx_start=1 and tx_ready=1.
REQ-008 tx_start  output  1  one-cycle request to the transmitter.
REQ-009 tx_data  output  DATA_BITS  character offered to the transmitter; held stable from tx_start until the next tx_start.
REQ-010 count  output  DEPTH_LOG2+1  number of characters stored.
REQ-011 empty, full  output  1 each  count==0 and count==2^DEPTH_LOG2 respectively.
REQ-012 overflow  output  1  sticky flag: at least one character was dropped.
REQ-013 clear_overflow  input  1  synchronous clear of overflow.

Function
REQ-014 Storage SHALL be a circular buffer with DEPTH_LOG2-bit read and write pointers that wrap from 2^DEPTH_LOG2-1 to 0.
REQ-015 Push: in_valid=1 and (not full, or pop in same cycle) SHALL write in_data at the write pointer and advance it.
REQ-016 in_valid=1 while full with no pop in the same cycle SHALL drop the character, leave pointers and count unchanged, and set overflow on the next edge.
REQ-017 count SHALL update on the same edge as the push/pop: +1 push only, -1 pop only, unchanged for both or neither.
REQ-018 Issue FSM SHALL have states IDLE, WAIT_BUSY.
REQ-019 In IDLE with tx_ready=1 and empty=0, tx_start SHALL be 1 for exactly that cycle (registered, asserted the cycle after the condition is seen), tx_data SHALL equal the head character in that cycle, the pop SHALL occur on that same edge, and the FSM SHALL go to WAIT_BUSY.
REQ-020 In WAIT_BUSY the FSM SHALL stay until tx_ready=0 is sampled, then return to IDLE; no tx_start SHALL be issued in WAIT_BUSY.
REQ-021 Throughput SHALL be one character per transmitter frame; latency from push into an empty buffer with tx_ready=1 to tx_start SHALL be 2 cycles.
REQ-022 clear_overflow=1 SHALL clear overflow on the next edge; if the same cycle also drops a character, overflow SHALL remain 1 (set wins).
REQ-023 A pop SHALL never occur while empty=1; a push into an empty buffer is not visible to the issue FSM until the following cycle.

Reset
REQ-024 n_reset=0 SHALL immediately, without a clock, force pointers=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=0, FSM=IDLE.
REQ-025 Reset asserted mid-transmission SHALL discard all stored characters; after release, no tx_start SHALL occur until a new push.
REQ-026 Release of n_reset SHALL be honoured synchronously: first state change on the first rising edge with n_reset=1.

Verification
REQ-027 Single byte: tx_ready=1, push 0x54 -> tx_start pulse 2 cycles later with tx_data=0x54, count back to 0, empty=1.
REQ-028 Burst: tx_ready=0, push 0x01..0x10 (16, DEPTH_LOG2=4) -> full=1, count=16; raise tx_ready, model transmitter busy 100 cycles per char -> 16 tx_start pulses with data 0x01..0x10 in order, no duplicates.
REQ-029 Overflow: fill 16, push 0xAA with tx_ready=0 -> 0xAA dropped, count=16, overflow=1; clear_overflow pulse -> overflow=0 next cycle.
REQ-030 Simultaneous push/pop at full: full, tx_ready=1 and in_valid=1 same cycle -> no drop, count stays 16, overflow=0, new byte emitted last.
REQ-031 Wrap-around: 40 push/transmit cycles with random data -> output sequence equals input sequence across pointer wraps.
REQ-032 Mid-operation reset: 5 bytes stored, assert n_reset asynchronously between edges -> outputs at reset values immediately; no tx_start after release until a new push.
